// File: rtl/fifo_pkg.sv
// Shared defaults and pointer type for the FIFO pointer controller.
// Depth is 2**FIFO_ADDR_W; pointers carry one extra wrap bit.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

    typedef logic [FIFO_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to reflected Gray code converter.
// Adjacent binary values map to codes differing in exactly one bit.
module binary_to_gray #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller with registered Gray pointers.
// Define FIFO_PTR_ERR_EN to add sticky overflow/underflow outputs.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int ADDR_W = FIFO_ADDR_W,
    localparam int PTR_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_accept,
    output logic              rd_accept,
    output logic              full,
    output logic              empty,
    output logic [PTR_W-1:0]  count,
    output logic [PTR_W-1:0]  wr_ptr_gray,
    output logic [PTR_W-1:0]  rd_ptr_gray
`ifdef FIFO_PTR_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_gray;
    logic [PTR_W-1:0] r_rd_gray;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_gray_nxt;
    logic [PTR_W-1:0] w_rd_gray_nxt;
    logic [PTR_W-1:0] w_count_nxt;
    logic             w_full_nxt;
    logic             w_empty_nxt;

    assign w_wr_accept = wr_en & ~r_full;
    assign w_rd_accept = rd_en & ~r_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr_accept);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_accept);

    // Flags come from the next-state pointers so they settle with them.
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign w_full_nxt  =
        (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
        (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
    assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

    binary_to_gray #(
        .SIZE (PTR_W)
    ) u_wr_gray (
        .bin  (w_wr_ptr_nxt),
        .gray (w_wr_gray_nxt)
    );

    binary_to_gray #(
        .SIZE (PTR_W)
    ) u_rd_gray (
        .bin  (w_rd_ptr_nxt),
        .gray (w_rd_gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_gray <= '0;
            r_rd_gray <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_wr_gray <= w_wr_gray_nxt;
            r_rd_gray <= w_rd_gray_nxt;
            r_count   <= w_count_nxt;
            r_full    <= w_full_nxt;
            r_empty   <= w_empty_nxt;
        end
    end

`ifdef FIFO_PTR_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A write into a full FIFO is only an error if no read frees a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_full && !w_rd_accept) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign wr_addr     = r_wr_ptr[ADDR_W-1:0];
    assign rd_addr     = r_rd_ptr[ADDR_W-1:0];
    assign wr_accept   = w_wr_accept;
    assign rd_accept   = w_rd_accept;
    assign full        = r_full;
    assign empty       = r_empty;
    assign count       = r_count;
    assign wr_ptr_gray = r_wr_gray;
    assign rd_ptr_gray = r_rd_gray;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (ADDR_W=4).
module tb_fifo_ptr_ctrl;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] wr_addr;
    logic [3:0] rd_addr;
    logic       wr_accept;
    logic       rd_accept;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
`ifdef FIFO_PTR_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_tests;
    int n_fail;

    fifo_ptr_ctrl #(
        .ADDR_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .wr_accept   (wr_accept),
        .rd_accept   (rd_accept),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray)
`ifdef FIFO_PTR_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty got %b want 1", empty);
        end
        n_tests++;
        if (full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full got %b want 0", full);
        end
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        n_tests++;
        if (wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d/%0d want 0/0", wr_addr, rd_addr);
        end
        n_tests++;
        if (wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_gray got %b/%b want 0/0",
                     wr_ptr_gray, rd_ptr_gray);
        end
`ifdef FIFO_PTR_ERR_EN
        n_tests++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got %b%b want 00", overflow, underflow);
        end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            #1;
            n_tests++;
            if (wr_accept !== 1'b1 || wr_addr !== 4'(i - 1)) begin
                n_fail++;
                $display("FAIL fill_accept[%0d] got acc=%b addr=%0d want 1/%0d",
                         i, wr_accept, wr_addr, i - 1);
            end
            tick();
            n_tests++;
            if (count !== 5'(i) || full !== (i == 16) || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_count[%0d] got c=%0d f=%b e=%b want %0d/%b/0",
                         i, count, full, empty, i, (i == 16));
            end
        end
        n_tests++;
        if (wr_ptr_gray !== 5'b11000) begin
            n_fail++;
            $display("FAIL fill_gray got %b want 11000", wr_ptr_gray);
        end
        wr_en = 1'b1;
        #1;
        n_tests++;
        if (wr_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL full_block got %b want 0", wr_accept);
        end
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (count !== 5'd16 || full !== 1'b1 || wr_addr !== 4'd0 ||
            wr_ptr_gray !== 5'b11000) begin
            n_fail++;
            $display("FAIL full_hold got c=%0d f=%b a=%0d g=%b want 16/1/0/11000",
                     count, full, wr_addr, wr_ptr_gray);
        end
`ifdef FIFO_PTR_ERR_EN
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set got %b want 1", overflow);
        end
`endif
    endtask

    task automatic test_full_rw();
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        n_tests++;
        if (wr_accept !== 1'b0 || rd_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL full_rw_accept got w=%b r=%b want 0/1",
                     wr_accept, rd_accept);
        end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_tests++;
        if (count !== 5'd15 || full !== 1'b0 || rd_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL full_rw got c=%0d f=%b ra=%0d want 15/0/1",
                     count, full, rd_addr);
        end
        n_tests++;
        if (rd_ptr_gray !== 5'b00001) begin
            n_fail++;
            $display("FAIL full_rw_gray got %b want 00001", rd_ptr_gray);
        end
    endtask

    task automatic test_stream();
        logic [4:0] wp;
        logic [4:0] rp;
        logic [4:0] pw;
        logic [4:0] pr;
        int         bad;
        do_reset();
        write_n(3);
        wp  = 5'd3;
        rp  = 5'd0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            pw    = wr_ptr_gray;
            pr    = rd_ptr_gray;
            wr_en = 1'b1;
            rd_en = 1'b1;
            #1;
            if (wr_accept !== 1'b1 || rd_accept !== 1'b1) bad++;
            tick();
            wp = wp + 5'd1;
            rp = rp + 5'd1;
            if (count !== 5'd3 || full !== 1'b0 || empty !== 1'b0) bad++;
            if ($countones(pw ^ wr_ptr_gray) != 1) bad++;
            if ($countones(pr ^ rd_ptr_gray) != 1) bad++;
            if (wr_ptr_gray !== (wp ^ (wp >> 1))) bad++;
            if (rd_ptr_gray !== (rp ^ (rp >> 1))) bad++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_steps got %0d bad steps want 0", bad);
        end
        n_tests++;
        if (wr_addr !== 4'd11 || rd_addr !== 4'd8) begin
            n_fail++;
            $display("FAIL stream_addr got %0d/%0d want 11/8", wr_addr, rd_addr);
        end
        n_tests++;
        if (wr_ptr_gray !== 5'b01110 || rd_ptr_gray !== 5'b01100) begin
            n_fail++;
            $display("FAIL stream_gray got %b/%b want 01110/01100",
                     wr_ptr_gray, rd_ptr_gray);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        rd_en = 1'b1;
        #1;
        n_tests++;
        if (rd_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_block got %b want 0", rd_accept);
        end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if (rd_addr !== 4'd0 || rd_ptr_gray !== 5'd0 || empty !== 1'b1 ||
            count !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_hold got ra=%0d g=%b e=%b c=%0d want 0/0/1/0",
                     rd_addr, rd_ptr_gray, empty, count);
        end
`ifdef FIFO_PTR_ERR_EN
        write_n(2);
        tick();
        n_tests++;
        if (underflow !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_sticky got u=%b o=%b want 1/0",
                     underflow, overflow);
        end
        do_reset();
        n_tests++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clear got %b want 0", underflow);
        end
`endif
    endtask

    task automatic test_empty_rw();
        do_reset();
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        n_tests++;
        if (wr_accept !== 1'b1 || rd_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rw_accept got w=%b r=%b want 1/0",
                     wr_accept, rd_accept);
        end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_tests++;
        if (count !== 5'd1 || empty !== 1'b0 || wr_addr !== 4'd1 ||
            rd_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL empty_rw got c=%0d e=%b wa=%0d ra=%0d want 1/0/1/0",
                     count, empty, wr_addr, rd_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_n(9);
        n_tests++;
        if (count !== 5'd9) begin
            n_fail++;
            $display("FAIL mid_prefill got %0d want 9", count);
        end
        reset = 1'b1;
        wr_en = 1'b1;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        n_tests++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
            wr_addr !== 4'd0 || rd_addr !== 4'd0 ||
            wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset got c=%0d e=%b wa=%0d g=%b want 0/1/0/0",
                     count, empty, wr_addr, wr_ptr_gray);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        test_reset();
        test_fill();
        test_full_rw();
        test_stream();
        test_underflow();
        test_empty_rw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer controller. Sequences the write and read pointers of a 2**ADDR_W-entry FIFO storage array and generates the full, empty and occupancy status. Also publishes registered Gray-coded copies of both pointers for the later dual-clock FIFO upgrade. Sits between the FIFO top level (which owns the RAM) and its producer and consumer.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.
PTR_W, ADDR_W+1, internal pointer width: the extra MSB is the wrap bit. Derived; must not be overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  producer write request.
rd_en  input  1  consumer read request.
wr_addr  output  ADDR_W  RAM write address = wr_ptr[ADDR_W-1:0].
rd_addr  output  ADDR_W  RAM read address = rd_ptr[ADDR_W-1:0].
wr_accept  output  1  RAM write strobe = wr_en & ~full.
rd_accept  output  1  read strobe = rd_en & ~empty.
full  output  1  FIFO holds 2**ADDR_W entries.
empty  output  1  FIFO holds 0 entries.
count  output  PTR_W  occupancy, 0 to 2**ADDR_W.
wr_ptr_gray  output  PTR_W  registered Gray code of wr_ptr.
rd_ptr_gray  output  PTR_W  registered Gray code of rd_ptr.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. It is sampled on the rising edge of clk and has priority over all other inputs.
- Reset values: wr_ptr=0, rd_ptr=0, wr_ptr_gray=0, rd_ptr_gray=0, count=0, empty=1, full=0, wr_addr=0, rd_addr=0.
- Reset mid-operation discards all occupancy. The storage array itself is not cleared.
- Write pointer: wr_ptr increments by 1 modulo 2**PTR_W on every edge where wr_accept=1.
- Read pointer: rd_ptr increments by 1 modulo 2**PTR_W on every edge where rd_accept=1.
- Write latency: wr_addr is valid in the same cycle as wr_en, and the RAM writes at that edge.
- Read latency: rd_addr is valid in the same cycle as rd_en, and read data is the RAM's concern.
- Flag decode: full, empty and count are registered, updated at the same edge as the pointers, and derived from the next-state pointers.
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) and (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
  - count = (wr_ptr - rd_ptr) modulo 2**PTR_W.
- Gray outputs: wr_ptr_gray and rd_ptr_gray are registered Gray conversions of the next-state pointers, so they change together with the binary pointers. Adjacent values differ in exactly one bit, including at wrap.
- Boundary conditions:
  - Write when full: blocked (wr_accept=0) and state unchanged, unless a read is also accepted in that cycle.
  - Read when empty: blocked (rd_accept=0).
  - Simultaneous accepted read and write: both pointers advance, count is unchanged, full and empty are unchanged.
  - Full with wr_en and rd_en both high: only the read is accepted; count drops to 2**ADDR_W-1 and full clears.
  - Empty with wr_en and rd_en both high: only the write is accepted; count becomes 1 and empty clears.
  - Pointer wrap from 2**PTR_W-1 to 0 is seamless and needs no special case.

Optional Feature:
Macro: FIFO_PTR_ERR_EN.
- Defined: adds output ports overflow (1) and underflow (1), both sticky and reset to 0.
  - overflow sets on any edge with wr_en=1 and full=1 and rd_accept=0.
  - underflow sets on any edge with rd_en=1 and empty=1.
  - Both clear only on reset.
- Undefined: the ports and logic are absent, and blocked requests are silently dropped.

Decomposition:
- Package fifo_pkg: parameter defaults FIFO_ADDR_W=4 and FIFO_PTR_W=FIFO_ADDR_W+1, and typedef ptr_t = logic [FIFO_PTR_W-1:0].
- Sub-module: reuse the existing binary_to_gray, instanced twice with SIZE=PTR_W (next-state wr_ptr and next-state rd_ptr). Its outputs are registered here.
- No FSM: state is the two pointers plus registered flags.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, all pointers and Gray outputs 0.
- 16 consecutive writes from reset (ADDR_W=4) -> count steps 1..16; full=1 after the 16th edge; wr_ptr_gray=5'b11000; a 17th wr_en gives wr_accept=0 and state unchanged.
- Fill 16, then hold wr_en=rd_en=1 for one cycle -> only the read is accepted; count=15, full=0, rd_addr advances to 1.
- Stream 40 simultaneous read/write pairs after 3 prefill writes -> count held at 3; both pointers wrap past 31→0; every Gray transition changes exactly 1 bit.
- rd_en asserted while empty -> rd_accept=0, rd_ptr unchanged; with FIFO_PTR_ERR_EN, underflow=1 and stays 1 until reset.
- Assert reset mid-stream with count=9 -> next edge: count=0, empty=1, pointers 0; wr_en in the same cycle as reset is ignored.
